// File: rtl/register_file_sb.sv
// register_file_sb: NUM_REGS x DATA_W register file with pending-write scoreboard.
// Latency: reads, hazards combinational; writes and scoreboard updates take effect after the rising edge.
// Backpressure: none; the ID-stage hazard unit stalls on hazard1/hazard2 before re-issuing.
// Optional feature: define RF_BYPASS_EN for same-cycle write-through from the write-back port
// to both read ports, with the matching hazard suppressed during the retire cycle.
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15   // must not exceed 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] Dest_wb,
  input  logic [DATA_W-1:0] Result_WB,
  input  logic              writeBackEn,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              flush,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              any_pending
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] wr_hit;   // one-hot write-back/retire target (empty when illegal)
  logic [NUM_REGS-1:0] iss_hit;  // one-hot issue target (empty when illegal)
  logic [NUM_REGS-1:0] byp_hit;  // registers whose read is forwarded from Result_WB

  // Decode write-back and issue addresses; out-of-range addresses match nothing
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i]  = writeBackEn && (Dest_wb == ADDR_W'(i));
      iss_hit[i] = issue_en && (issue_dest == ADDR_W'(i));
    end
  end

`ifdef RF_BYPASS_EN
  assign byp_hit = wr_hit;
`else
  assign byp_hit = '0;
`endif

  // Register array: reset loads each register with its own index, write-back on the rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= Result_WB;
        end
      end
    end
  end

  // Scoreboard: flush clears everything, otherwise issue wins over a same-register retire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wr_hit) | iss_hit;
    end
  end

  // Read ports and hazards; illegal source addresses read zero with no hazard
  always_comb begin
    reg1    = '0;
    reg2    = '0;
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src1 == ADDR_W'(i)) begin
        reg1    = byp_hit[i] ? Result_WB : regs[i];
        hazard1 = pending[i] & ~byp_hit[i];
      end
      if (src2 == ADDR_W'(i)) begin
        reg2    = byp_hit[i] ? Result_WB : regs[i];
        hazard2 = pending[i] & ~byp_hit[i];
      end
    end
  end

  // Depends only on registered scoreboard state, never on this cycle's inputs
  assign any_pending = |pending;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus random traffic, scoreboard-checked
// against an array-based behavioural model of the register file and pending set.
module tb_register_file_sb;

  localparam int NR = 15;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  src1 = '0, src2 = '0, Dest_wb = '0, issue_dest = '0;
  logic [31:0] Result_WB = '0;
  logic        writeBackEn = 1'b0, issue_en = 1'b0, flush = 1'b0;
  logic [31:0] reg1, reg2;
  logic        hazard1, hazard2, any_pending;

  register_file_sb dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Dest_wb(Dest_wb),
    .Result_WB(Result_WB), .writeBackEn(writeBackEn), .issue_en(issue_en),
    .issue_dest(issue_dest), .flush(flush), .reg1(reg1), .reg2(reg2),
    .hazard1(hazard1), .hazard2(hazard2), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        h1;
    logic        h2;
    logic        ap;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          rst_val = 1'b0;

  // Behavioural model state
  logic [31:0] m_regs [NR];
  bit          m_pend [NR];

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = 32'(i);
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] model_read(logic [3:0] s, bit we, logic [3:0] d, logic [31:0] dat);
    if (int'(s) >= NR) return 32'h0;
    if (BYP && we && d == s) return dat;
    return m_regs[s];
  endfunction

  function automatic bit model_hazard(logic [3:0] s, bit we, logic [3:0] d);
    if (int'(s) >= NR) return 1'b0;
    return m_pend[s] && !(BYP && we && d == s);
  endfunction

  function automatic bit model_any();
    bit a = 1'b0;
    for (int i = 0; i < NR; i++) a |= m_pend[i];
    return a;
  endfunction

  function automatic exp_t predict(string nm);
    exp_t e;
    e.name = nm;
    e.r1 = model_read(src1, writeBackEn, Dest_wb, Result_WB);
    e.r2 = model_read(src2, writeBackEn, Dest_wb, Result_WB);
    e.h1 = model_hazard(src1, writeBackEn, Dest_wb);
    e.h2 = model_hazard(src2, writeBackEn, Dest_wb);
    e.ap = model_any();
    return e;
  endfunction

  // What the coming rising edge does to the model
  function automatic void model_edge();
    if (writeBackEn && int'(Dest_wb) < NR) m_regs[Dest_wb] = Result_WB;
    if (flush) begin
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    end else begin
      if (writeBackEn && int'(Dest_wb) < NR) m_pend[Dest_wb] = 1'b0;
      if (issue_en && int'(issue_dest) < NR) m_pend[issue_dest] = 1'b1;
    end
  endfunction

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, fld, act, want, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge, queue the expected response, advance the model
  task automatic step(input logic [3:0] s1, input logic [3:0] s2, input bit we,
                      input logic [3:0] d, input logic [31:0] dat, input bit iss,
                      input logic [3:0] id, input bit fl, input string nm);
    @(posedge clk);
    #1;
    rst = rst_val;
    src1 = s1; src2 = s2; writeBackEn = we; Dest_wb = d; Result_WB = dat;
    issue_en = iss; issue_dest = id; flush = fl;
    exp_q.push_back(predict(nm));
    if (rst_val) model_edge();
  endtask

  // Pull reset low between edges; outputs must reflect reset before the next edge
  task automatic async_reset(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rst_val = 1'b0;
    model_reset();
    exp_q.push_back(predict(nm));
  endtask

  // Monitor: compare queued expectations against DUT outputs at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "reg1", reg1, e.r1);
        chk(e.name, "reg2", reg2, e.r2);
        chk(e.name, "hazard1", 32'(hazard1), 32'(e.h1));
        chk(e.name, "hazard2", 32'(hazard2), 32'(e.h2));
        chk(e.name, "any_pending", 32'(any_pending), 32'(e.ap));
      end
    end
  end

  initial begin
    model_reset();
    // Held in reset: reads show the index pattern, write attempts ignored
    rst_val = 1'b0;
    step(4'd3, 4'd9, 1'b1, 4'd3, 32'hFFFF_0000, 1'b1, 4'd3, 1'b0, "in_reset");
    step(4'd3, 4'd9, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "in_reset2");
    rst_val = 1'b1;
    for (int i = 0; i < NR; i++)
      step(4'(i), 4'(NR - 1 - i), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "reset_sweep");
    step(4'd15, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "read_r15");

    // Write then read back; illegal destination changes nothing
    step(4'd3, 4'd0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b0, "write_r3");
    step(4'd3, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "read_r3");
    step(4'd15, 4'd14, 1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1, 4'd15, 1'b0, "write_r15");
    for (int i = 0; i < NR; i++)
      step(4'(i), 4'(NR - 1 - i), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "post_r15_sweep");

    // Issue, observe hazard, retire with data
    step(4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0, "issue_r5");
    step(4'd0, 4'd5, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "hazard_r5");
    step(4'd0, 4'd5, 1'b1, 4'd5, 32'h1234, 1'b0, 4'd0, 1'b0, "retire_r5");
    step(4'd0, 4'd5, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "after_retire_r5");

    // Same-cycle issue and retire on R7 keeps it pending
    step(4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0, "issue_r7");
    step(4'd7, 4'd0, 1'b1, 4'd7, 32'h77, 1'b1, 4'd7, 1'b0, "iss_ret_r7");
    step(4'd7, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "r7_still_pending");

    // Flush overrides a same-cycle issue
    step(4'd2, 4'd7, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b1, "flush_issue_r2");
    step(4'd2, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "after_flush");

    // Retire cycle on both ports at once (write-through only with bypass)
    step(4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 1'b0, "issue_r4");
    step(4'd4, 4'd4, 1'b1, 4'd4, 32'hA5A5_A5A5, 1'b0, 4'd0, 1'b0, "retire_r4_bypass");
    step(4'd4, 4'd4, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "after_r4");

    // Asynchronous reset with live state
    step(4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0, "issue_r9");
    step(4'd4, 4'd9, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "pre_async");
    async_reset("async_reset");
    rst_val = 1'b1;
    step(4'd4, 4'd9, 1'b1, 4'd9, 32'hCAFE_F00D, 1'b1, 4'd1, 1'b0, "release");
    step(4'd9, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, "first_edge_after_release");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0), "random");
    end

    repeat (3) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
